// File: rtl/centroid_multi_stat.sv
// Blob statistics over a binarised pixel stream: per-frame area, first moments and a
// sequential restoring divider for the centroid. Optional CENTROID_BBOX_EN adds a bounding box.
module centroid_multi_stat #(
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int COORD_W  = 12,
  parameter int AREA_W   = 20,
  parameter int SUM_W    = 32,
  parameter int MIN_AREA = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               de,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               mask,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [AREA_W-1:0]  area,
  output logic               found,
  output logic               valid,
  output logic               overrun
`ifdef CENTROID_BBOX_EN
  ,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max
`endif
);

  localparam logic [COORD_W-1:0] LP_X_LAST    = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] LP_Y_LAST    = COORD_W'(IMG_H - 1);
  localparam logic [AREA_W-1:0]  LP_MIN_AREA  = AREA_W'(MIN_AREA);
  localparam int                 CNT_W        = $clog2(SUM_W);
  localparam logic [CNT_W-1:0]   LP_LAST_STEP = CNT_W'(SUM_W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_DIV, ST_DONE} state_t;

  state_t              r_state;
  logic                r_vsync_q;
  logic                r_de_q;
  logic                r_armed;
  logic                r_overrun;
  logic [COORD_W-1:0]  r_pos_x;
  logic [COORD_W-1:0]  r_pos_y;
  logic [AREA_W-1:0]   r_m00;
  logic [SUM_W-1:0]    r_sum_x;
  logic [SUM_W-1:0]    r_sum_y;

  logic [AREA_W-1:0]   r_div_m00;
  logic                r_div_ok;
  logic [CNT_W-1:0]    r_cnt;
  logic [SUM_W-1:0]    r_num [2];
  logic [AREA_W-1:0]   r_rem [2];

  logic [COORD_W-1:0]  r_x;
  logic [COORD_W-1:0]  r_y;
  logic [AREA_W-1:0]   r_area;
  logic                r_found;
  logic                r_valid;

  logic                w_frame_edge;
  logic                w_pix;
  logic                w_busy;
  logic                w_start;
  logic                w_unused_hsync;
  logic [AREA_W-1:0]   w_m00_next;
  logic [SUM_W:0]      w_sum_x_wide;
  logic [SUM_W:0]      w_sum_y_wide;
  logic [SUM_W-1:0]    w_sum_x_next;
  logic [SUM_W-1:0]    w_sum_y_next;
  logic [SUM_W-1:0]    w_dividend [2];
  logic [AREA_W:0]     w_trial [2];
  logic                w_ge [2];
  logic [AREA_W-1:0]   w_rem_next [2];

  assign w_unused_hsync = hsync;
  assign w_frame_edge   = vsync & ~r_vsync_q;
  assign w_pix          = de & mask;
  assign w_busy         = (r_state != ST_IDLE);
  assign w_start        = w_frame_edge & r_armed & ~w_busy;

  // Saturating accumulators: stick at all-ones instead of wrapping.
  assign w_m00_next   = (r_m00 == '1) ? r_m00 : r_m00 + AREA_W'(1);
  assign w_sum_x_wide = {1'b0, r_sum_x} + (SUM_W+1)'(r_pos_x);
  assign w_sum_y_wide = {1'b0, r_sum_y} + (SUM_W+1)'(r_pos_y);
  assign w_sum_x_next = w_sum_x_wide[SUM_W] ? '1 : w_sum_x_wide[SUM_W-1:0];
  assign w_sum_y_next = w_sum_y_wide[SUM_W] ? '1 : w_sum_y_wide[SUM_W-1:0];

  assign w_dividend[0] = r_sum_x;
  assign w_dividend[1] = r_sum_y;

  // One restoring-division step per axis; r_num shifts dividend out and quotient in.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      assign w_trial[gi]    = {r_rem[gi], r_num[gi][SUM_W-1]};
      assign w_ge[gi]       = (w_trial[gi] >= {1'b0, r_div_m00});
      assign w_rem_next[gi] = w_ge[gi] ? AREA_W'(w_trial[gi] - {1'b0, r_div_m00})
                                       : w_trial[gi][AREA_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsync_q <= 1'b0;
      r_de_q    <= 1'b0;
      r_armed   <= 1'b0;
      r_overrun <= 1'b0;
      r_pos_x   <= '0;
      r_pos_y   <= '0;
      r_m00     <= '0;
      r_sum_x   <= '0;
      r_sum_y   <= '0;
    end else begin
      r_vsync_q <= vsync;
      r_de_q    <= de;
      r_overrun <= w_frame_edge & r_armed & w_busy;
      if (w_frame_edge) begin
        // A pixel on the edge cycle belongs to the new frame at (0,0).
        r_armed <= 1'b1;
        r_pos_y <= '0;
        r_pos_x <= (de && (LP_X_LAST != '0)) ? COORD_W'(1) : '0;
        r_m00   <= w_pix ? AREA_W'(1) : '0;
        r_sum_x <= '0;
        r_sum_y <= '0;
      end else begin
        if (r_de_q && !de) begin
          r_pos_x <= '0;
          if (r_pos_y != LP_Y_LAST) r_pos_y <= r_pos_y + COORD_W'(1);
        end else if (de && (r_pos_x != LP_X_LAST)) begin
          r_pos_x <= r_pos_x + COORD_W'(1);
        end
        if (w_pix) begin
          r_m00   <= w_m00_next;
          r_sum_x <= w_sum_x_next;
          r_sum_y <= w_sum_y_next;
        end
      end
    end
  end

`ifdef CENTROID_BBOX_EN
  logic [COORD_W-1:0] r_run_xmin, r_run_xmax, r_run_ymin, r_run_ymax;
  logic [COORD_W-1:0] r_snap_xmin, r_snap_xmax, r_snap_ymin, r_snap_ymax;
  logic [COORD_W-1:0] r_out_xmin, r_out_xmax, r_out_ymin, r_out_ymax;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_xmin <= '1;
      r_run_xmax <= '0;
      r_run_ymin <= '1;
      r_run_ymax <= '0;
    end else if (w_frame_edge) begin
      r_run_xmin <= w_pix ? '0 : '1;
      r_run_xmax <= '0;
      r_run_ymin <= w_pix ? '0 : '1;
      r_run_ymax <= '0;
    end else if (w_pix) begin
      if (r_pos_x < r_run_xmin) r_run_xmin <= r_pos_x;
      if (r_pos_x > r_run_xmax) r_run_xmax <= r_pos_x;
      if (r_pos_y < r_run_ymin) r_run_ymin <= r_pos_y;
      if (r_pos_y > r_run_ymax) r_run_ymax <= r_pos_y;
    end
  end

  assign x_min = r_out_xmin;
  assign x_max = r_out_xmax;
  assign y_min = r_out_ymin;
  assign y_max = r_out_ymax;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_div_m00 <= '0;
      r_div_ok  <= 1'b0;
      r_cnt     <= '0;
      for (int i = 0; i < 2; i++) begin
        r_num[i] <= '0;
        r_rem[i] <= '0;
      end
      r_x       <= '0;
      r_y       <= '0;
      r_area    <= '0;
      r_found   <= 1'b0;
      r_valid   <= 1'b0;
`ifdef CENTROID_BBOX_EN
      r_snap_xmin <= '0;
      r_snap_xmax <= '0;
      r_snap_ymin <= '0;
      r_snap_ymax <= '0;
      r_out_xmin  <= '0;
      r_out_xmax  <= '0;
      r_out_ymin  <= '0;
      r_out_ymax  <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_div_m00 <= r_m00;
            for (int i = 0; i < 2; i++) begin
              r_num[i] <= w_dividend[i];
              r_rem[i] <= '0;
            end
`ifdef CENTROID_BBOX_EN
            r_snap_xmin <= r_run_xmin;
            r_snap_xmax <= r_run_xmax;
            r_snap_ymin <= r_run_ymin;
            r_snap_ymax <= r_run_ymax;
`endif
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_cnt <= '0;
          if ((r_div_m00 == '0) || (r_div_m00 < LP_MIN_AREA)) begin
            r_div_ok <= 1'b0;
            r_state  <= ST_DONE;
          end else begin
            r_div_ok <= 1'b1;
            r_state  <= ST_DIV;
          end
        end
        ST_DIV: begin
          for (int i = 0; i < 2; i++) begin
            r_num[i] <= {r_num[i][SUM_W-2:0], w_ge[i]};
            r_rem[i] <= w_rem_next[i];
          end
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LP_LAST_STEP) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_valid <= 1'b1;
          r_area  <= r_div_m00;
          r_found <= r_div_ok;
          if (r_div_ok) begin
            r_x <= r_num[0][COORD_W-1:0];
            r_y <= r_num[1][COORD_W-1:0];
`ifdef CENTROID_BBOX_EN
            r_out_xmin <= r_snap_xmin;
            r_out_xmax <= r_snap_xmax;
            r_out_ymin <= r_snap_ymin;
            r_out_ymax <= r_snap_ymax;
`endif
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign x       = r_x;
  assign y       = r_y;
  assign area    = r_area;
  assign found   = r_found;
  assign valid   = r_valid;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_centroid_multi_stat.sv
// Randomised bench for centroid_multi_stat: two instances (MIN_AREA 1 and 4) share one
// stimulus stream; a frame-level arithmetic model predicts every result and overrun pulse.
module tb_centroid_multi_stat;

  localparam int IMG_W   = 64;
  localparam int IMG_H   = 64;
  localparam int COORD_W = 12;
  localparam int AREA_W  = 20;
  localparam int SUM_W   = 32;
  localparam int LAT_FOUND = SUM_W + 2;
  localparam int LAT_EMPTY = 2;
  localparam int MAXR = 72;
  localparam int MAXC = 72;

  logic clk = 1'b0, rst = 1'b1, de = 1'b0, hsync = 1'b0, vsync = 1'b0, mask = 1'b0;
  logic [COORD_W-1:0] x0, y0, x1, y1;
  logic [AREA_W-1:0]  a0, a1;
  logic f0, f1, v0, v1, o0, o1;
  logic [COORD_W-1:0] bb0 [4];
  logic [COORD_W-1:0] bb1 [4];

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  centroid_multi_stat #(.IMG_W(IMG_W), .IMG_H(IMG_H), .COORD_W(COORD_W), .AREA_W(AREA_W),
                        .SUM_W(SUM_W), .MIN_AREA(1)) u_dut (
    .clk(clk), .rst(rst), .de(de), .hsync(hsync), .vsync(vsync), .mask(mask),
    .x(x0), .y(y0), .area(a0), .found(f0), .valid(v0), .overrun(o0)
`ifdef CENTROID_BBOX_EN
    , .x_min(bb0[0]), .x_max(bb0[1]), .y_min(bb0[2]), .y_max(bb0[3])
`endif
  );

  centroid_multi_stat #(.IMG_W(IMG_W), .IMG_H(IMG_H), .COORD_W(COORD_W), .AREA_W(AREA_W),
                        .SUM_W(SUM_W), .MIN_AREA(4)) u_dut_min4 (
    .clk(clk), .rst(rst), .de(de), .hsync(hsync), .vsync(vsync), .mask(mask),
    .x(x1), .y(y1), .area(a1), .found(f1), .valid(v1), .overrun(o1)
`ifdef CENTROID_BBOX_EN
    , .x_min(bb1[0]), .x_max(bb1[1]), .y_min(bb1[2]), .y_max(bb1[3])
`endif
  );

`ifndef CENTROID_BBOX_EN
  initial for (int i = 0; i < 4; i++) begin bb0[i] = '0; bb1[i] = '0; end
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int cyc; bit found; int x; int y; int area; int bb[4];
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   ov0[$];
  int   ov1[$];
  int   min_area[2] = '{1, 4};
  int   busy_end[2] = '{-1, -1};
  int   hold_x[2], hold_y[2];
  int   hold_bb[2][4];
  bit   armed = 1'b0;
  int   f_cnt;
  longint f_sx, f_sy;
  int   f_bb[4];
  bit   fm [MAXR][MAXC];

  function automatic int clamp(input int v, input int hi);
    return (v > hi) ? hi : v;
  endfunction

  task automatic clear_frame_model();
    f_cnt = 0; f_sx = 0; f_sy = 0;
    f_bb = '{IMG_W, 0, IMG_H, 0};
  endtask

  task automatic model_pixel(input int c, input int r);
    int cx, ry;
    cx = clamp(c, IMG_W - 1);
    ry = clamp(r, IMG_H - 1);
    f_cnt++; f_sx += cx; f_sy += ry;
    if (cx < f_bb[0]) f_bb[0] = cx;
    if (cx > f_bb[1]) f_bb[1] = cx;
    if (ry < f_bb[2]) f_bb[2] = ry;
    if (ry > f_bb[3]) f_bb[3] = ry;
  endtask

  task automatic model_edge(input int k);
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (armed) begin
        if (k <= busy_end[d]) begin
          if (d == 0) ov0.push_back(k); else ov1.push_back(k);
        end else begin
          e.found = (f_cnt > 0) && (f_cnt >= min_area[d]);
          e.area  = f_cnt;
          if (e.found) begin
            hold_x[d] = int'(f_sx / f_cnt);
            hold_y[d] = int'(f_sy / f_cnt);
            for (int i = 0; i < 4; i++) hold_bb[d][i] = f_bb[i];
          end
          e.x = hold_x[d];
          e.y = hold_y[d];
          for (int i = 0; i < 4; i++) e.bb[i] = hold_bb[d][i];
          e.cyc = k + (e.found ? LAT_FOUND : LAT_EMPTY);
          busy_end[d] = e.cyc;
          if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
      end
    end
    armed = 1'b1;
    clear_frame_model();
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); ov0.delete(); ov1.delete();
    armed = 1'b0;
    for (int d = 0; d < 2; d++) begin
      busy_end[d] = -1; hold_x[d] = 0; hold_y[d] = 0;
      for (int i = 0; i < 4; i++) hold_bb[d][i] = 0;
    end
    clear_frame_model();
  endtask

  // ---------------- monitor ----------------
  task automatic mon_dut(input int d, input logic v, input logic ov,
                         input logic [COORD_W-1:0] xo, input logic [COORD_W-1:0] yo,
                         input logic [AREA_W-1:0] ao, input logic fo,
                         input logic [COORD_W-1:0] b0, input logic [COORD_W-1:0] b1,
                         input logic [COORD_W-1:0] b2, input logic [COORD_W-1:0] b3);
    exp_t e;
    int   oc;
    if ((d == 0) ? (q0.size() > 0) : (q1.size() > 0)) begin
      e = (d == 0) ? q0[0] : q1[0];
      if (e.cyc < cyc) begin
        check_value($sformatf("dut%0d_valid_missing", d), 0, 1);
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
    if (v === 1'b1) begin
      if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
        check_value($sformatf("dut%0d_valid_unexpected", d), 1, 0);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        $display("[TB] dut%0d result cyc=%0d x=%0d y=%0d area=%0d found=%0d", d, cyc, xo, yo, ao, fo);
        check_value($sformatf("dut%0d_valid_cycle", d), cyc, e.cyc);
        check_value($sformatf("dut%0d_found", d), fo, e.found);
        check_value($sformatf("dut%0d_area", d), ao, e.area);
        check_value($sformatf("dut%0d_x", d), xo, e.x);
        check_value($sformatf("dut%0d_y", d), yo, e.y);
`ifdef CENTROID_BBOX_EN
        check_value($sformatf("dut%0d_x_min", d), b0, e.bb[0]);
        check_value($sformatf("dut%0d_x_max", d), b1, e.bb[1]);
        check_value($sformatf("dut%0d_y_min", d), b2, e.bb[2]);
        check_value($sformatf("dut%0d_y_max", d), b3, e.bb[3]);
`endif
      end
    end
    if ((d == 0) ? (ov0.size() > 0) : (ov1.size() > 0)) begin
      oc = (d == 0) ? ov0[0] : ov1[0];
      if (oc < cyc) begin
        check_value($sformatf("dut%0d_overrun_missing", d), 0, 1);
        if (d == 0) void'(ov0.pop_front()); else void'(ov1.pop_front());
      end
    end
    if (ov === 1'b1) begin
      if ((d == 0) ? (ov0.size() == 0) : (ov1.size() == 0)) begin
        check_value($sformatf("dut%0d_overrun_unexpected", d), 1, 0);
      end else begin
        oc = (d == 0) ? ov0.pop_front() : ov1.pop_front();
        $display("[TB] dut%0d overrun cyc=%0d", d, cyc);
        check_value($sformatf("dut%0d_overrun_cycle", d), cyc, oc);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon_dut(0, v0, o0, x0, y0, a0, f0, bb0[0], bb0[1], bb0[2], bb0[3]);
      mon_dut(1, v1, o1, x1, y1, a1, f1, bb1[0], bb1[1], bb1[2], bb1[3]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_edge();
    de = 1'b0; mask = 1'b0; vsync = 1'b1;
    tick();
    model_edge(cyc);
    vsync = 1'b0;
  endtask

  task automatic wait_idle();
    int m;
    m = (busy_end[0] > busy_end[1]) ? busy_end[0] : busy_end[1];
    while (cyc <= m + 1) tick();
  endtask

  task automatic clear_fm();
    for (int r = 0; r < MAXR; r++)
      for (int c = 0; c < MAXC; c++) fm[r][c] = 1'b0;
  endtask

  task automatic send_frame(input int nrows, input int ncols, input int gap);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < ncols; c++) begin
        de = 1'b1; mask = fm[r][c];
        if (fm[r][c]) model_pixel(c, r);
        tick();
      end
      de = 1'b0; mask = 1'b0; hsync = 1'b1;
      tick();
      hsync = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_value({tag, "_x"}, x0, 0);
    check_value({tag, "_y"}, y0, 0);
    check_value({tag, "_area"}, a0, 0);
    check_value({tag, "_found"}, f0, 0);
    check_value({tag, "_valid"}, v0, 0);
    check_value({tag, "_overrun"}, o0, 0);
    check_value({tag, "_x_min4"}, x1, 0);
    check_value({tag, "_area_min4"}, a1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    model_reset();
    rst = 1'b1;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst = 1'b0;
    tick();

    // arm, then single pixel at (5,3)
    frame_edge();
    clear_fm(); fm[3][5] = 1'b1;
    send_frame(6, 8, 2); wait_idle(); frame_edge();

    // 2x2 block at cols 10..11, rows 20..21
    clear_fm(); fm[20][10] = 1; fm[20][11] = 1; fm[21][10] = 1; fm[21][11] = 1;
    send_frame(22, 12, 2); wait_idle(); frame_edge();

    // empty frame: found=0, previous x/y held
    clear_fm(); send_frame(4, 8, 2); wait_idle(); frame_edge();

    // 3 pixels then 4 pixels around the MIN_AREA=4 threshold
    clear_fm(); fm[1][2] = 1; fm[2][3] = 1; fm[4][6] = 1;
    send_frame(5, 8, 2); wait_idle(); frame_edge();
    clear_fm(); fm[1][2] = 1; fm[2][3] = 1; fm[4][6] = 1; fm[4][7] = 1;
    send_frame(5, 8, 2); wait_idle(); frame_edge();

    // second frame edge 10 cycles after a snapshot: overrun, first result kept
    clear_fm(); for (int i = 0; i < 6; i++) fm[i][i + 1] = 1;
    send_frame(7, 9, 1); wait_idle(); frame_edge();
    repeat (9) tick();
    frame_edge();
    clear_fm(); fm[2][4] = 1; fm[3][4] = 1; fm[3][5] = 1; fm[5][9] = 1; fm[6][1] = 1;
    send_frame(8, 12, 2); wait_idle(); frame_edge();

    // pixels beyond the image clamp at the last column/row
    clear_fm(); fm[65][70] = 1; fm[2][66] = 1; fm[64][3] = 1; fm[10][10] = 1;
    send_frame(66, 71, 1); wait_idle(); frame_edge();

    // randomised frames
    for (int n = 0; n < 10; n++) begin
      int nr, nc, dens;
      nr = $urandom_range(24, 1); nc = $urandom_range(40, 1); dens = $urandom_range(60, 0);
      clear_fm();
      for (int r = 0; r < nr; r++)
        for (int c = 0; c < nc; c++) fm[r][c] = ($urandom_range(99, 0) < dens);
      send_frame(nr, nc, $urandom_range(3, 1)); wait_idle(); frame_edge();
    end

    // reset in the middle of a division
    clear_fm(); fm[8][8] = 1; fm[8][9] = 1; fm[9][8] = 1; fm[9][9] = 1; fm[3][30] = 1;
    send_frame(10, 32, 1); wait_idle(); frame_edge();
    k = cyc;
    while (cyc < k + 15) tick();
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs_zero("mid_div_reset");
    tick(); tick();
    rst = 1'b0;
    tick();
    clear_fm(); fm[1][1] = 1; fm[2][2] = 1; fm[3][3] = 1; fm[4][4] = 1;
    send_frame(5, 6, 2); frame_edge();
    send_frame(5, 6, 2); wait_idle(); frame_edge();
    clear_fm(); fm[0][7] = 1; fm[12][40] = 1; fm[6][20] = 1; fm[7][21] = 1;
    send_frame(13, 41, 1); wait_idle(); frame_edge();

    wait_idle();
    repeat (4) tick();
    check_value("pending_results", q0.size() + q1.size() + ov0.size() + ov1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/centroid_multi_stat.md
Name: centroid_multi_stat

Overview:
Second-generation blob-statistics block for the video path. It sits after the binarisation mask stage and consumes the same de/hsync/vsync/mask pixel stream as the existing centroid logic. Per frame it accumulates area and first moments, then divides with an internal sequential divider and reports centroid, area, a found flag and an overrun flag. Widths, image size and minimum-area threshold are parametrised, and no divider IP is required.

Parameters:
IMG_W, 64, active pixels per line; pos_x range 0..IMG_W-1
IMG_H, 64, active lines per frame; pos_y range 0..IMG_H-1
COORD_W, 12, width of coordinate counters and x/y outputs
AREA_W, 20, width of area accumulator m00
SUM_W, 32, width of moment accumulators and divider dividend
MIN_AREA, 1, minimum m00 for a valid object; below it found=0

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
de  in  1  data enable, active pixel
hsync  in  1  line sync; accepted, not used for counting
vsync  in  1  frame sync; its rising edge is the frame boundary
mask  in  1  binary object pixel
x  out  COORD_W  centroid column, floor(sum_x/m00)
y  out  COORD_W  centroid row, floor(sum_y/m00)
area  out  AREA_W  m00 of the last completed frame
found  out  1  last result had m00>=MIN_AREA
valid  out  1  one-cycle pulse when x/y/area/found update
overrun  out  1  one-cycle pulse when a frame result is dropped

Behaviour:
- Reset (async, active-high): x=0, y=0, area=0, found=0, valid=0, overrun=0, accumulators=0, pos_x=0, pos_y=0, divider IDLE, armed=0, vsync_q=0.
- Position: pos_x increments on each de=1 cycle. On de falling edge (de_q=1, de=0): pos_x<=0, pos_y<=pos_y+1. pos_x and pos_y stop incrementing at IMG_W-1 and IMG_H-1 (no wrap) until the next frame edge.
- Accumulation: on de&mask, m00+=1, sum_x+=pos_x, sum_y+=pos_y. The value used is the pre-increment pos_x of that cycle. Each accumulator saturates at its all-ones value.
- Frame edge (vsync=1 & vsync_q=0), at that clock edge:
  - If armed=1 and the divider is IDLE: snapshot m00/sum_x/sum_y, then start the divider.
  - Clear the accumulators, pos_x and pos_y, and set armed<=1.
  - A de&mask pixel in the same cycle is counted into the new frame, with pos=(0,0).
  - The first frame edge after reset only arms the block. No result is produced.
- Divider FSM: IDLE -> CHECK -> DIV -> DONE -> IDLE.
  - CHECK (1 cycle): if snapshot m00<MIN_AREA or m00==0, go to DONE with found=0. Otherwise go to DIV.
  - DIV: restoring division, one quotient bit per cycle, x and y computed in parallel, SUM_W cycles.
  - DONE (1 cycle): register outputs and pulse valid.
- Result latency:
  - found=1: valid asserts SUM_W+2 cycles after the snapshot edge (edge k -> valid high in cycle k+SUM_W+2).
  - found=0: valid asserts at k+2.
- found=0 result: x and y hold their previous values; area is updated to the snapshot m00.
- Quotient width: the quotient is truncated to COORD_W. It cannot exceed IMG_W-1 or IMG_H-1 unless the sums saturated.
- Frame edge while the divider is busy: the new snapshot is discarded and overrun pulses for 1 cycle. The running division completes unaffected. Accumulators still clear.
- rst during DIV: the division aborts, valid does not pulse, and all outputs return to their reset values.

Optional Feature:
Macro CENTROID_BBOX_EN.
- Defined: adds outputs x_min, x_max, y_min, y_max (COORD_W each, reset 0), tracked per frame over de&mask pixels. They are snapshotted at the frame edge and presented with valid. When found=0 they hold their previous values.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
1. IMG 64x64, SUM_W=32, arm frame, then one mask pixel at (5,3) -> valid at k+34, x=5, y=3, area=1, found=1.
2. 2x2 block at columns 10..11, rows 20..21 -> x=10, y=20 (floor of 10.5/20.5), area=4, found=1.
3. Frame with no mask pixels after test 2 -> valid at k+2, found=0, area=0, x=10, y=20 held.
4. MIN_AREA=4 with 3 mask pixels -> found=0, area=3, valid at k+2. The same frame with 4 pixels gives found=1.
5. Second vsync rising edge 10 cycles after the snapshot -> overrun pulses once. The first result is still valid at k+34. No second valid follows.
6. rst at k+15 mid-division -> no valid pulse, outputs 0. The next frame edge only re-arms. With CENTROID_BBOX_EN, test 2 gives x_min=10, x_max=11, y_min=20, y_max=21.
